// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing types and constants for the a0 logger.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEWLINE} tx_state_t;
  localparam logic [7:0] UART_NEWLINE = 8'h0A;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && (!full || pop);
  assign rdata = mem[rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/a0_uart_logger.sv
// a0_uart_logger: queues each change of a0 and sends it MSB byte first as 8N1 UART frames.
// Define A0_LOG_NEWLINE_EN to follow every word with a framed 0x0A byte.
module a0_uart_logger
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         a0_i,
  input  logic                          en_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  tx_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_idx;
  logic [DATA_WIDTH-1:0] a0_prev, word, fifo_data;
  logic push, pop, full, empty, tick, last_byte, nl;
  logic [7:0] cur_byte;
  assign push = en_i && a0_i != a0_prev;
  assign pop = state == IDLE && !empty;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_byte = byte_idx == BW'(NB - 1);
  assign cur_byte = nl ? UART_NEWLINE : word[(NB - 1 - int'(byte_idx)) * 8 +: 8];
  assign busy_o = state != IDLE;
  assign tx_o = state == DATA ? cur_byte[bit_idx] : !(state == START || state == NEWLINE);
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(a0_i),
    .rdata(fifo_data), .count(fifo_count_o), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:           state_n = empty ? IDLE : START;
      START, NEWLINE: state_n = tick ? DATA : state;
      DATA:           state_n = tick && bit_idx == 3'd7 ? STOP : DATA;
`ifdef A0_LOG_NEWLINE_EN
      STOP:           state_n = !tick ? STOP : nl ? IDLE : last_byte ? NEWLINE : START;
`else
      STOP:           state_n = !tick ? STOP : last_byte ? IDLE : START;
`endif
      default:        state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      a0_prev <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_n;
      a0_prev <= a0_i;
      overflow_o <= overflow_o | (push && full && !pop);
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      bit_idx <= state != DATA ? '0 : tick ? bit_idx + 3'd1 : bit_idx;
      if (pop) begin
        word <= fifo_data;
        byte_idx <= '0;
      end else if (state == STOP && tick && !last_byte) begin
        byte_idx <= byte_idx + BW'(1);
      end
    end
  end
`ifdef A0_LOG_NEWLINE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nl <= 1'b0;
    else nl <= state == NEWLINE ? 1'b1 : state == IDLE ? 1'b0 : nl;
  end
`else
  assign nl = 1'b0;
`endif
endmodule

// File: tb/tb_a0_uart_logger.sv
// tb_a0_uart_logger: vector table plus UART receiver scoreboard for a0_uart_logger.
module tb_a0_uart_logger;
  localparam int C = 4;
`ifdef A0_LOG_NEWLINE_EN
  localparam int NBW = 5;
`else
  localparam int NBW = 4;
`endif
  localparam int WC = NBW * 10 * C;
  typedef struct {
    logic        en;
    logic [31:0] a0;
    logic [2:0]  cnt;
    logic        tx;
    logic        busy;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en_i = 1'b0;
  logic [31:0] a0_i = '0;
  logic tx_o, busy_o, overflow_o;
  logic [2:0] fifo_count_o;
  int errs = 0, checks = 0;
  logic [31:0] exp_q[$];
  a0_uart_logger #(.DATA_WIDTH(32), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .a0_i(a0_i), .en_i(en_i), .tx_o(tx_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .fifo_count_o(fifo_count_o)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] v, input bit acc);
    a0_i = v;
    if (acc) exp_q.push_back(v);
  endtask

  initial begin : rx
    logic [7:0] b;
    logic [31:0] w;
    int nb;
    bit ab;
    nb = 0;
    w = '0;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst && tx_o === 1'b0) begin
        ab = 1'b0;
        repeat (2) @(negedge clk);
        ab |= rst;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx_o;
          ab |= rst;
        end
        repeat (4) @(negedge clk);
        ab |= rst;
        if (ab) nb = 0;
        else begin
          chk("stop_bit", {31'd0, tx_o}, 32'd1);
          if (nb < 4) w = {w[23:0], b};
          else chk("newline_byte", {24'd0, b}, 32'h0A);
          nb++;
          if (nb == NBW) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errs++;
              $display("FAIL rx_unexpected: got %0h expected no word", w);
            end else chk("rx_word", w, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [31:0] words[2];
    logic [31:0] ov_vals[6];
    logic [2:0] ov_cnt[6];
    bit ov_acc[6];
    int bad, t;
    vecs = '{'{1'b1, 32'h0, 3'd0, 1'b1, 1'b0},
             '{1'b0, 32'h5, 3'd0, 1'b1, 1'b0},
             '{1'b0, 32'h9, 3'd0, 1'b1, 1'b0},
             '{1'b0, 32'h0, 3'd0, 1'b1, 1'b0},
             '{1'b0, 32'h7, 3'd0, 1'b1, 1'b0},
             '{1'b1, 32'h7, 3'd0, 1'b1, 1'b0}};
    words = '{32'h12345678, 32'h000000FF};
    ov_vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    ov_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ov_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (3) step();
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst_count", {29'd0, fifo_count_o}, 32'd0);
    rst = 1'b0;
    step();
    foreach (vecs[i]) begin
      en_i = vecs[i].en;
      a0_i = vecs[i].a0;
      step();
      chk($sformatf("vec%0d_count", i), {29'd0, fifo_count_o}, {29'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_tx", i), {31'd0, tx_o}, {31'd0, vecs[i].tx});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_o}, {31'd0, vecs[i].busy});
    end
    en_i = 1'b1;
    foreach (words[i]) begin
      drive(words[i], 1'b1);
      step();
      chk("push_count", {29'd0, fifo_count_o}, 32'd1);
      chk("push_busy", {31'd0, busy_o}, 32'd0);
      step();
      chk("pop_count", {29'd0, fifo_count_o}, 32'd0);
      chk("pop_busy", {31'd0, busy_o}, 32'd1);
      chk("start_tx", {31'd0, tx_o}, 32'd0);
      bad = 0;
      repeat (WC - 1) begin
        step();
        if (!busy_o) bad++;
      end
      chk("busy_span", bad, 0);
      step();
      chk("word_end_busy", {31'd0, busy_o}, 32'd0);
      for (t = 0; t < 100 && exp_q.size() != 0; t++) step();
      chk("word_rx_done", exp_q.size(), 0);
    end
    foreach (ov_vals[k]) begin
      drive(ov_vals[k], ov_acc[k]);
      step();
      chk($sformatf("ov%0d_count", k), {29'd0, fifo_count_o}, {29'd0, ov_cnt[k]});
      chk($sformatf("ov%0d_flag", k), {31'd0, overflow_o}, k == 5 ? 32'd1 : 32'd0);
    end
    repeat (WC - 4) step();
    chk("full_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("full_idle_count", {29'd0, fifo_count_o}, 32'd4);
    drive(32'h77, 1'b1);
    step();
    chk("pushpop_count", {29'd0, fifo_count_o}, 32'd4);
    chk("pushpop_ovf", {31'd0, overflow_o}, 32'd1);
    chk("pushpop_busy", {31'd0, busy_o}, 32'd1);
    chk("pushpop_tx", {31'd0, tx_o}, 32'd0);
    for (t = 0; t < 6 * WC && (exp_q.size() != 0 || busy_o || fifo_count_o != 0); t++) step();
    chk("drain_done", {31'd0, exp_q.size() == 0 && !busy_o && fifo_count_o == 0}, 32'd1);
    drive(32'hAA00BBCC, 1'b1);
    step();
    drive(32'h12, 1'b1);
    step();
    repeat (57) step();
    chk("mid_tx_bit3", {31'd0, tx_o}, 32'd0);
    chk("mid_busy", {31'd0, busy_o}, 32'd1);
    chk("mid_count", {29'd0, fifo_count_o}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    a0_i = '0;
    #1;
    chk("arst_tx", {31'd0, tx_o}, 32'd1);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_count", {29'd0, fifo_count_o}, 32'd0);
    chk("arst_ovf", {31'd0, overflow_o}, 32'd0);
    repeat (5) step();
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (!tx_o || busy_o || fifo_count_o != 0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_q", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/a0_uart_logger.md
# a0_uart_logger

Downstream consumer of the CPU's `a0` output: watches `a0` for changes, queues each new value in a small FIFO, and serialises queued words over a UART TX line as 8N1 bytes. It sits beside the CPU top level on the board wrapper. It gives a bench or a host PC a cycle-independent trace of program results without probing internal nets.

## Interface
- `DATA_WIDTH`, 32, width of `a0`; must be a multiple of 8.
- `CLKS_PER_BIT`, 868, `clk` cycles per UART bit; minimum 2.
- `FIFO_DEPTH`, 4, queued words; power of two, minimum 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `a0_i`  in  DATA_WIDTH  CPU `a0` register value.
- `en_i`  in  1  logging enable; changes are ignored while low.
- `tx_o`  out  1  UART serial output, idle high.
- `busy_o`  out  1  high while a word is being serialised.
- `overflow_o`  out  1  sticky flag: a change was dropped because the FIFO was full.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  words currently queued.

## Operation
- **Change detect.** Register `a0_prev` resets to 0 and loads `a0_i` every cycle, regardless of `en_i`.
  - `push = en_i && (a0_i != a0_prev)`.
  - The value written to the FIFO is `a0_i`.
- **FIFO.** Circular buffer with wrapping read and write pointers and an explicit count.
  - Push while full (count == FIFO_DEPTH) is dropped, with `overflow_o` set to 1. The flag is cleared only by `rst`.
  - If a push and a pop occur in the same cycle, both take effect, even when the FIFO is full, and the count is unchanged.
  - A pop from an empty FIFO never occurs.
- **TX FSM** states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop one word into the shift register, set byte index to 0, and go to START.
  - START: drive `tx_o` low for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive `tx_o` high for CLKS_PER_BIT cycles.
    - If byte index < DATA_WIDTH/8 − 1, increment the index and go to START.
    - Otherwise go to IDLE.
- **Byte order.** Most significant byte first. For 32-bit `a0`, bytes go out as [31:24], [23:16], [15:8], [7:0].
- `busy_o` is high in every state other than IDLE.
- **Baud counter.** Counts from 0 to CLKS_PER_BIT−1 and resets to 0 on every state entry. Bit and state advance when the counter reaches CLKS_PER_BIT−1.

## Timing
- **Reset values:** `tx_o`=1, `busy_o`=0, `overflow_o`=0, `fifo_count_o`=0, FSM=IDLE, `a0_prev`=0, pointers=0.
- **Reset mid-transmission** aborts the frame immediately: `tx_o` goes high asynchronously and all queued words are discarded.
- **Push latency.** `a0_i` changes before edge N; the push is committed at edge N, and `fifo_count_o` reflects it after edge N.
- **Pop latency.** The pop occurs on the first edge where the FSM is in IDLE with count > 0. `tx_o` falls (start bit) after that same edge.
- **Word length.** One word occupies exactly (DATA_WIDTH/8)·10·CLKS_PER_BIT cycles from the start-bit edge to the return to IDLE. There is no idle gap between bytes of a word.
- **Back-to-back words.** Consecutive queued words are separated by exactly one IDLE cycle.
- **First value.** A first nonzero `a0` after reset is logged; `a0` remaining 0 is not.
- **Multiple changes.** If `a0` changes several times within one word's transmission time, every change is queued, up to the FIFO depth.

## Configuration
- `A0_LOG_NEWLINE_EN`
  - **Defined:** after the last data byte's STOP, the FSM sends one extra framed byte 0x0A before returning to IDLE. This adds state NEWLINE, which reuses the START/DATA/STOP timing, and word time becomes (DATA_WIDTH/8+1)·10·CLKS_PER_BIT cycles. `busy_o` stays high through the newline byte.
  - **Not defined:** no terminator byte; behaviour is exactly as described above.

## Structure
- Shared package `uart_pkg`:
  - enum `tx_state_t` (IDLE, START, DATA, STOP, NEWLINE);
  - constant `UART_NEWLINE` = 8'h0A;
  - localparam helpers for bits per frame (10).
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH). It provides push, pop, data, count and full/empty outputs. The change detector, FSM and baud counter live in `a0_uart_logger`.

## Test plan
- **Single word:** CLKS_PER_BIT=4, `a0_i` 0→0x12345678 with `en_i`=1 → `tx_o` frames 0x12, 0x34, 0x56, 0x78, LSB first. Total 160 cycles; `busy_o` high throughout, then low.
- **Enable gating:** `en_i`=0 while `a0_i` changes 0→5→9 → `fifo_count_o` stays 0 and `tx_o` stays 1.
- **Overflow:** FIFO_DEPTH=4, `a0_i` takes 6 distinct values on consecutive cycles → first word transmits. After push/pop accounting the count reaches 4, `overflow_o`=1, and the 6th value is not received.
- **Simultaneous push/pop at full:** FIFO full, IDLE pop coincides with a new change → count stays 4, the new value is queued, and `overflow_o` is unchanged.
- **Reset mid-frame:** assert `rst` during the DATA bit 3 of byte 2 → `tx_o`=1 immediately, and `fifo_count_o`=0 and `busy_o`=0 after reset.
- **Newline:** with `A0_LOG_NEWLINE_EN` defined, `a0_i`=0x000000FF → bytes 0x00, 0x00, 0x00, 0xFF, 0x0A; 200 cycles at CLKS_PER_BIT=4.
